// File: rtl/core_step_ctrl.sv
// core_step_ctrl: run/halt/single-step controller that gates a soft core via
// a clock enable. It also handles three debounced push buttons, a
// breakpoint halt input, and holds the core in reset after power-up.

// Button conditioner: two-flop synchronizer, stability-window debouncer and
// a one-cycle pulse on every debounced press (release gives nothing).
module core_step_ctrl_deb #(
  parameter int DEB_CYCLES = 12000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_raw,
  output logic press_ev
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic          ev_q, ev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level follows the synchronized input only after it has disagreed for a full window
  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    ev_d = level_d & ~level_q;
  end

  // Conditioner state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      ev_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_ev = ev_q;

endmodule

// Top level: button conditioning, reset sequencing, the run/halt/step FSM,
// the slow-run divider and the core-cycle counter.
module core_step_ctrl #(
  parameter int DEB_CYCLES = 12000,
  parameter int SLOW_DIV   = 12000000,
  parameter int RST_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_speed,
  input  logic        halt_req,
  output logic        core_ce,
  output logic        core_rst,
  output logic [1:0]  state,
  output logic        slow,
  output logic [15:0] step_count
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STEP  = 2'd3;

  localparam int DW = $clog2(SLOW_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SLOW_DIV - 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  logic          run_ev, step_ev, speed_ev;
  logic          ce_w;
  logic          rst_meta_q, rst_meta_d;
  logic          rst_sync_q, rst_sync_d;
  logic [1:0]    state_q, state_d;
  logic          slow_q, slow_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [15:0]   step_count_q, step_count_d;

  core_step_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_run), .press_ev(run_ev)
  );

  core_step_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_step), .press_ev(step_ev)
  );

  core_step_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_speed), .press_ev(speed_ev)
  );

  // Core enable is decoded purely from registers so it cannot glitch on button activity
  always_comb begin
    ce_w = (state_q == ST_STEP) ||
           ((state_q == ST_RUN) && (!slow_q || (div_q == DIV_LAST)));
  end

  // Next-state logic: reset hold, run/halt/step decisions, speed toggle, divider and counter
  always_comb begin
    rst_meta_d   = 1'b1;
    rst_sync_d   = rst_meta_q;
    state_d      = state_q;
    slow_d       = slow_q;
    div_d        = div_q;
    rst_cnt_d    = '0;
    step_count_d = step_count_q;

    case (state_q)
      ST_RESET: begin
        if (rst_sync_q) begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = ST_HALT;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (run_ev && !halt_req) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_ev) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (run_ev || halt_req) begin
          state_d = ST_HALT;
        end
        if (slow_q) begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (speed_ev && (state_q != ST_RESET)) begin
      slow_d = ~slow_q;
      div_d  = '0;
    end

    if (state_q == ST_RESET) begin
      step_count_d = '0;
    end else begin
      step_count_d = step_count_q + {15'd0, ce_w};
    end
  end

  // Controller registers; the reset release walks through a two-flop synchronizer first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_q   <= 1'b0;
      rst_sync_q   <= 1'b0;
      state_q      <= ST_RESET;
      slow_q       <= 1'b0;
      div_q        <= '0;
      rst_cnt_q    <= '0;
      step_count_q <= '0;
    end else begin
      rst_meta_q   <= rst_meta_d;
      rst_sync_q   <= rst_sync_d;
      state_q      <= state_d;
      slow_q       <= slow_d;
      div_q        <= div_d;
      rst_cnt_q    <= rst_cnt_d;
      step_count_q <= step_count_d;
    end
  end

  // Output decodes of the registered state
  always_comb begin
    core_ce    = ce_w;
    core_rst   = (state_q == ST_RESET);
    state      = state_q;
    slow       = slow_q;
    step_count = step_count_q;
  end

endmodule
